// File: rtl/vending_machine_multi_pkg.sv
// Shared types for the multi-product vending machine: FSM states, coin codes
// and the coin-code-to-value mapping.
package vm_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      VEND    = 2'd2,
      CHANGE  = 2'd3
   } state_t;

   localparam logic [1:0] COIN_NONE = 2'b00;
   localparam logic [1:0] COIN1     = 2'b01;
   localparam logic [1:0] COIN2     = 2'b10;
   localparam logic [1:0] COIN3     = 2'b11;

   function automatic int unsigned coin_value(input logic [1:0] code,
                                              input int unsigned v1,
                                              input int unsigned v2,
                                              input int unsigned v3);
      case (code)
         COIN1:   return v1;
         COIN2:   return v2;
         COIN3:   return v3;
         default: return 0;
      endcase
   endfunction

endpackage

// File: rtl/vending_machine_multi_if.sv
// Front-end / actuator bundle of the vending machine. The refund line exists
// only when VM_REFUND_EN is defined.
interface vending_machine_multi_if #(
   parameter int NUM_ITEMS = 4,
   parameter int CREDIT_W  = 8
);
   localparam int SEL_W = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1;

   logic [1:0]          in;
   logic                sel_valid;
   logic [SEL_W-1:0]    sel;
   logic                restock;
`ifdef VM_REFUND_EN
   logic                refund;
`endif
   logic                out;
   logic [SEL_W-1:0]    item;
   logic [1:0]          change;
   logic [CREDIT_W-1:0] credit;
   logic                busy;
   logic                coin_rej;
   logic                sold_out;
   logic                short_pay;

   modport master (
      output in, sel_valid, sel, restock,
`ifdef VM_REFUND_EN
      output refund,
`endif
      input  out, item, change, credit, busy, coin_rej, sold_out, short_pay
   );

   modport slave (
      input  in, sel_valid, sel, restock,
`ifdef VM_REFUND_EN
      input  refund,
`endif
      output out, item, change, credit, busy, coin_rej, sold_out, short_pay
   );
endinterface

// File: rtl/vm_change_pick.sv
// Greedy change selector: largest coin not exceeding the given credit.
module vm_change_pick
   import vm_pkg::*;
#(
   parameter int CREDIT_W  = 8,
   parameter int COIN1_VAL = 5,
   parameter int COIN2_VAL = 10,
   parameter int COIN3_VAL = 25
) (
   input  logic [CREDIT_W-1:0] credit,
   output logic [1:0]          code,
   output logic [CREDIT_W-1:0] value
);
   always_comb begin
      code = COIN_NONE;
      if (credit >= CREDIT_W'(COIN3_VAL))      code = COIN3;
      else if (credit >= CREDIT_W'(COIN2_VAL)) code = COIN2;
      else if (credit >= CREDIT_W'(COIN1_VAL)) code = COIN1;
      value = CREDIT_W'(coin_value(code, COIN1_VAL, COIN2_VAL, COIN3_VAL));
   end
endmodule

// File: rtl/vending_machine_multi.sv
// Multi-product vending machine: credit accumulation, per-item stock, greedy
// change. Defining VM_REFUND_EN adds the refund path.
module vending_machine_multi
   import vm_pkg::*;
#(
   parameter int NUM_ITEMS  = 4,
   parameter int CREDIT_W   = 8,
   parameter int MAX_CREDIT = 100,
   parameter int COIN1_VAL  = 5,
   parameter int COIN2_VAL  = 10,
   parameter int COIN3_VAL  = 25,
   parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICES = {8'd65, 8'd50, 8'd35, 8'd25},
   parameter int STOCK_W    = 4,
   parameter int STOCK_INIT = 3
) (
   input logic                    clk,
   input logic                    rst,
   vending_machine_multi_if.slave bus
);
   localparam int SEL_W = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1;
   localparam int CW1   = CREDIT_W + 1;

   state_t              state, state_nx, base_nx;
   logic [CREDIT_W-1:0] credit_q, credit_nx;
   logic [SEL_W-1:0]    item_q, item_nx;
   logic [1:0]          change_q, change_nx;
   logic [CREDIT_W-1:0] change_val_q;
   logic [STOCK_W-1:0]  stock [NUM_ITEMS];
   logic                out_q, busy_q, coin_rej_q, sold_out_q, short_pay_q;
   logic                coin_rej_nx, sold_out_nx, short_pay_nx;
   logic                change_req, vend_dec, refund_go, sel_ok;
   logic [CW1-1:0]      coin_sum;
   logic [1:0]          pick_code;
   logic [CREDIT_W-1:0] pick_value;

   function automatic logic [CREDIT_W-1:0] price_of(input logic [SEL_W-1:0] idx);
      logic [CREDIT_W-1:0] p;
      p = '0;
      for (int i = 0; i < NUM_ITEMS; i++)
         if (idx == SEL_W'(i)) p = PRICES[i*CREDIT_W +: CREDIT_W];
      return p;
   endfunction

`ifdef VM_REFUND_EN
   assign refund_go = bus.refund && (credit_q != '0);
`else
   assign refund_go = 1'b0;
`endif
   assign sel_ok = (int'(bus.sel) < NUM_ITEMS);

   // The pick always looks at the credit being loaded, so the coin shown on
   // change is the one taken out at the following edge.
   vm_change_pick #(
      .CREDIT_W (CREDIT_W),
      .COIN1_VAL(COIN1_VAL),
      .COIN2_VAL(COIN2_VAL),
      .COIN3_VAL(COIN3_VAL)
   ) u_pick (
      .credit(credit_nx),
      .code  (pick_code),
      .value (pick_value)
   );

   always_comb begin
      base_nx      = state;
      change_req   = 1'b0;
      credit_nx    = credit_q;
      item_nx      = item_q;
      vend_dec     = 1'b0;
      coin_rej_nx  = 1'b0;
      sold_out_nx  = 1'b0;
      short_pay_nx = 1'b0;
      coin_sum     = {1'b0, credit_q} + CW1'(coin_value(bus.in, COIN1_VAL, COIN2_VAL, COIN3_VAL));
      case (state)
         IDLE, COLLECT: begin
            if (refund_go) begin
               change_req  = 1'b1;
               coin_rej_nx = (bus.in != COIN_NONE);
            end else if (bus.sel_valid) begin
               coin_rej_nx = (bus.in != COIN_NONE);
               if (sel_ok) begin
                  if (stock[bus.sel] == '0)             sold_out_nx  = 1'b1;
                  else if (credit_q < price_of(bus.sel)) short_pay_nx = 1'b1;
                  else begin
                     base_nx = VEND;
                     item_nx = bus.sel;
                  end
               end
            end else if (bus.in != COIN_NONE) begin
               if (coin_sum <= CW1'(MAX_CREDIT)) begin
                  credit_nx = coin_sum[CREDIT_W-1:0];
                  base_nx   = COLLECT;
               end else begin
                  coin_rej_nx = 1'b1;
               end
            end
         end
         VEND: begin
            coin_rej_nx = (bus.in != COIN_NONE);
            credit_nx   = credit_q - price_of(item_q);
            vend_dec    = 1'b1;
            change_req  = 1'b1;
         end
         CHANGE: begin
            coin_rej_nx = (bus.in != COIN_NONE);
            credit_nx   = credit_q - change_val_q;
            change_req  = 1'b1;
         end
         default: base_nx = IDLE;
      endcase
   end

   always_comb begin
      state_nx  = base_nx;
      change_nx = COIN_NONE;
      if (change_req) begin
         if (credit_nx != '0 && pick_code != COIN_NONE) begin
            state_nx  = CHANGE;
            change_nx = pick_code;
         end else begin
            state_nx  = IDLE;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         credit_q    <= '0;
         item_q      <= '0;
         change_q    <= COIN_NONE;
         out_q       <= 1'b0;
         busy_q      <= 1'b0;
         coin_rej_q  <= 1'b0;
         sold_out_q  <= 1'b0;
         short_pay_q <= 1'b0;
         for (int i = 0; i < NUM_ITEMS; i++) stock[i] <= STOCK_W'(STOCK_INIT);
      end else begin
         state       <= state_nx;
         credit_q    <= credit_nx;
         item_q      <= item_nx;
         change_q    <= change_nx;
         out_q       <= (state_nx == VEND);
         busy_q      <= (state_nx == VEND) || (state_nx == CHANGE);
         coin_rej_q  <= coin_rej_nx;
         sold_out_q  <= sold_out_nx;
         short_pay_q <= short_pay_nx;
         // Restock overrides the decrement of a vend in the same cycle.
         if (bus.restock) begin
            for (int i = 0; i < NUM_ITEMS; i++) stock[i] <= STOCK_W'(STOCK_INIT);
         end else if (vend_dec && stock[item_q] != '0) begin
            stock[item_q] <= stock[item_q] - 1'b1;
         end
      end
   end

   // Only consumed while in CHANGE, after it has been loaded.
   always_ff @(posedge clk) begin
      change_val_q <= pick_value;
   end

   assign bus.out       = out_q;
   assign bus.item      = item_q;
   assign bus.change    = change_q;
   assign bus.credit    = credit_q;
   assign bus.busy      = busy_q;
   assign bus.coin_rej  = coin_rej_q;
   assign bus.sold_out  = sold_out_q;
   assign bus.short_pay = short_pay_q;
endmodule
